pbuf_pingpong: RTL and testbench
================================

Name: pbuf_pingpong

Overview:
- Double-buffered (ping-pong) parameter buffer directly downstream of the DDR-to-pbuf loader; sinks its single write address, 4 lane write-enables and per-lane BATCH-wide write data.
- Holds two sides of 4 banks each. The loader fills one side while the PE array reads the other.
- Side ownership moves by two handshakes: fill-complete (writer) and release (reader).

Parameters:
- BUF_DEPTH, 256, words per bank per side.
- ADDR_W, bw(BUF_DEPTH), per-side word address width.
- DATA_W, GLOBAL_PARAM::DATA_W, element width.
- BATCH, GLOBAL_PARAM::BATCH, elements per word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_addr  in  ADDR_W  write address, shared by all 4 lanes.
- wr_data  in  [3:0][DATA_W*BATCH]  per-lane write data.
- wr_en  in  4  per-lane write enable.
- wr_done  in  1  1-cycle pulse: current write side is completely filled.
- wr_ready  out  1  current write side is free for filling.
- rd_addr  in  [3:0][ADDR_W]  per-lane read address.
- rd_en  in  4  per-lane read request.
- rd_data  out  [3:0][DATA_W*BATCH]  per-lane read data.
- rd_valid  out  4  per-lane read data valid.
- rd_ready  out  1  current read side holds valid filled data.
- rd_release  in  1  1-cycle pulse: reader has finished with the current read side.
- wr_sel  out  1  side index currently owned by the writer.
- rd_sel  out  1  side index currently owned by the reader.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- State:
  - full[1:0] per-side flag.
  - wsel, rsel side pointers.
  - wr_ready = !full[wsel]; rd_ready = full[rsel].
  - wr_sel = wsel; rd_sel = rsel.
- Reset (async assert, sync deassert use):
  - full=0, wsel=0, rsel=0, rd_valid=0, rd_data=0, err=0.
  - RAM contents are not cleared.
  - Reset mid-fill or mid-read discards both sides logically (both empty).
- Write:
  - When wr_ready, each lane j with wr_en[j]=1 writes wr_data[j] to bank j at {wsel, wr_addr} in the same clock edge.
  - When !wr_ready, writes are dropped and err is set.
- wr_done:
  - If wr_ready: full[wsel]<=1 and wsel<=~wsel next edge.
  - Else: ignored, err set.
  - A write and wr_done in the same cycle: the write lands on the old side.
- Read:
  - rd_en[j] at cycle t with rd_ready=1 reads bank j at {rsel, rd_addr[j]}.
  - rd_data[j] is driven and rd_valid[j]=1 at t+2 (RAM register + output register). Fixed 2-cycle latency, fully pipelined, 1 read per lane per cycle.
  - rd_en while !rd_ready: no read, rd_valid stays 0, err is not set (idle polling is legal).
  - rd_data holds its last value when rd_valid=0.
- rd_release:
  - If rd_ready: full[rsel]<=0 and rsel<=~rsel.
  - Else: ignored, err set.
  - Reads issued in the release cycle are still served from the old side (pipeline completes).
- Simultaneous wr_done and rd_release:
  - Both apply.
  - They always target different sides: a full side is never the write side, and an empty side is never the read side.
- Both sides full: wr_ready=0 until a release.
- Both sides empty: rd_ready=0.
- Same-address write/read conflict cannot occur, because the writer and reader own disjoint sides.

Decomposition:
- Shared package GLOBAL_PARAM: DATA_W, BATCH, bw().
- Add PBUF_SIDES=2 constant there.
- Sub-module sdp_ram:
  - Simple dual-port, 1 write / 1 read port.
  - Depth 2*BUF_DEPTH, width DATA_W*BATCH, registered read.
  - Instantiated 4 times, one per lane.
- Control (full flags, pointers, err, valid pipeline) lives in the top level.

Test Plan:
- Fill side 0:
  - Stimulus: addr 0..255, lanes 0xF, data = {lane, addr}; then wr_done.
  - Response: wr_sel=1, rd_ready=1, rd_sel=0.
  - Then read lane 2 addr 17 at cycle t: rd_valid[2] at t+2 with data {2,17}.
- Ping-pong overlap:
  - Stimulus: fill side 1 while streaming reads from side 0, then wr_done.
  - Response: wr_ready=0 (both full).
  - Then rd_release: rsel=1, wr_ready=1, wsel=0; side-1 data read back correctly.
- Simultaneous events:
  - Stimulus: side 0 full/reading, side 1 filling; wr_done and rd_release in the same cycle.
  - Response: full=2'b10, rsel=1, wsel=0, err=0.
- Protocol errors:
  - Stimulus: wr_en=0x1 while both sides full.
  - Response: target word unchanged, err=1 sticky.
  - Stimulus: rd_release while rd_ready=0.
  - Response: no pointer change.
- Partial lane enables:
  - Stimulus: wr_en=4'b0101 at addr 5.
  - Response: only banks 0 and 2 updated; banks 1 and 3 retain prior data.
- Async reset:
  - Stimulus: assert rst_n=0 mid-read with rd_en active.
  - Response: rd_valid=0 immediately, full=0, rd_ready=0, wr_ready=1, wsel=rsel=0, err=0.

Source files
------------

// File: rtl/pbuf_pingpong_pkg.sv
// Shared global parameters for the parameter-buffer datapath.
// Element width, batch size, side count and a bit-width helper.
package GLOBAL_PARAM;

  localparam int DATA_W     = 8;
  localparam int BATCH      = 4;
  localparam int PBUF_SIDES = 2;

  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pbuf_pingpong_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Read data appears one cycle after re; contents are never reset.
module sdp_ram
  import GLOBAL_PARAM::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  parameter int AW    = bw(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pbuf_pingpong.sv
// Ping-pong parameter buffer: loader fills one side of 4 banks while the PE array reads the other.
// Reads have a fixed 2-cycle latency; ownership flips on wr_done / rd_release handshakes.
module pbuf_pingpong #(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = GLOBAL_PARAM::bw(BUF_DEPTH),
  parameter int DATA_W    = GLOBAL_PARAM::DATA_W,
  parameter int BATCH     = GLOBAL_PARAM::BATCH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [3:0][DATA_W*BATCH-1:0]     wr_data,
  input  logic [3:0]                       wr_en,
  input  logic                             wr_done,
  output logic                             wr_ready,
  input  logic [3:0][ADDR_W-1:0]           rd_addr,
  input  logic [3:0]                       rd_en,
  output logic [3:0][DATA_W*BATCH-1:0]     rd_data,
  output logic [3:0]                       rd_valid,
  output logic                             rd_ready,
  input  logic                             rd_release,
  output logic                             wr_sel,
  output logic                             rd_sel,
  output logic                             err
);
  import GLOBAL_PARAM::*;

  localparam int WORD_W = DATA_W * BATCH;
  localparam int RAM_AW = ADDR_W + 1;

  logic [PBUF_SIDES-1:0]   full, full_nxt;
  logic                    wsel, rsel, wsel_nxt, rsel_nxt, err_nxt;
  logic [3:0]              rd_stage;
  logic [3:0][WORD_W-1:0]  ram_q;

  assign wr_ready = !full[wsel];
  assign rd_ready = full[rsel];
  assign wr_sel   = wsel;
  assign rd_sel   = rsel;

  // wr_done and rd_release always address different sides, so both may apply at once.
  always_comb begin
    full_nxt = full;
    wsel_nxt = wsel;
    rsel_nxt = rsel;
    err_nxt  = err;
    if (wr_done) begin
      if (wr_ready) begin
        full_nxt[wsel] = 1'b1;
        wsel_nxt       = ~wsel;
      end else begin
        err_nxt = 1'b1;
      end
    end
    if (rd_release) begin
      if (rd_ready) begin
        full_nxt[rsel] = 1'b0;
        rsel_nxt       = ~rsel;
      end else begin
        err_nxt = 1'b1;
      end
    end
    if ((|wr_en) && !wr_ready) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      err  <= 1'b0;
    end else begin
      full <= full_nxt;
      wsel <= wsel_nxt;
      rsel <= rsel_nxt;
      err  <= err_nxt;
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_lane
    sdp_ram #(
      .DEPTH (PBUF_SIDES * BUF_DEPTH),
      .WIDTH (WORD_W),
      .AW    (RAM_AW)
    ) u_ram (
      .clk   (clk),
      .we    (wr_en[j] & wr_ready),
      .waddr ({wsel, wr_addr}),
      .wdata (wr_data[j]),
      .re    (rd_en[j] & rd_ready),
      .raddr ({rsel, rd_addr[j]}),
      .rdata (ram_q[j])
    );
  end

  // Stage 1 tracks the RAM register, stage 2 is the output register that holds data when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_stage <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_stage <= rd_en & {4{rd_ready}};
      rd_valid <= rd_stage;
      for (int j = 0; j < 4; j++) begin
        if (rd_stage[j]) rd_data[j] <= ram_q[j];
      end
    end
  end

endmodule

// File: tb/tb_pbuf_pingpong.sv
// Randomized bench for pbuf_pingpong with a behavioural model and per-cycle comparison.
// Directed phases pin the model with literal expectations.
module tb_pbuf_pingpong;

  logic              clk;
  logic              rst_n;
  logic [7:0]        wr_addr;
  logic [3:0][31:0]  wr_data;
  logic [3:0]        wr_en;
  logic              wr_done;
  logic              wr_ready;
  logic [3:0][7:0]   rd_addr;
  logic [3:0]        rd_en;
  logic [3:0][31:0]  rd_data;
  logic [3:0]        rd_valid;
  logic              rd_ready;
  logic              rd_release;
  logic              wr_sel;
  logic              rd_sel;
  logic              err;

  pbuf_pingpong dut (
    .clk(clk), .rst_n(rst_n), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .wr_done(wr_done), .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_release(rd_release),
    .wr_sel(wr_sel), .rd_sel(rd_sel), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-side full flags, two pointers, a word array per lane,
  // and a small schedule of read results keyed by the edge they become visible.
  logic [31:0]       mm [4][512];
  logic [1:0]        m_full;
  logic              m_wsel, m_rsel, m_err;
  logic [3:0]        m_vld;
  logic [3:0][31:0]  m_dat;
  logic [3:0]        slot_v [4];
  logic [3:0][31:0]  slot_d [4];
  int                kcnt;
  logic              m_wrdy, m_rrdy;

  assign m_wrdy = !m_full[m_wsel];
  assign m_rrdy = m_full[m_rsel];

  function automatic logic [1:0] nxt_full(input logic [1:0] f, input logic ws, input logic rs,
                                          input logic d, input logic r);
    logic [1:0] n;
    n = f;
    if (d && !f[ws]) n[ws] = 1'b1;
    if (r && f[rs])  n[rs] = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 2'b00;
      m_wsel <= 1'b0;
      m_rsel <= 1'b0;
      m_err  <= 1'b0;
      m_vld  <= 4'h0;
      m_dat  <= '0;
      kcnt   <= 0;
      for (int s = 0; s < 4; s++) begin
        slot_v[s] <= 4'h0;
        slot_d[s] <= '0;
      end
    end else begin
      m_vld <= slot_v[kcnt % 4];
      slot_v[kcnt % 4] <= 4'h0;
      for (int l = 0; l < 4; l++) begin
        if (slot_v[kcnt % 4][l]) m_dat[l] <= slot_d[kcnt % 4][l];
        slot_v[(kcnt + 1) % 4][l] <= rd_en[l] && m_rrdy;
        slot_d[(kcnt + 1) % 4][l] <= mm[l][{m_rsel, rd_addr[l]}];
        if (m_wrdy && wr_en[l]) mm[l][{m_wsel, wr_addr}] <= wr_data[l];
      end
      m_full <= nxt_full(m_full, m_wsel, m_rsel, wr_done, rd_release);
      m_wsel <= m_wsel ^ (wr_done && m_wrdy);
      m_rsel <= m_rsel ^ (rd_release && m_rrdy);
      m_err  <= m_err | (wr_done && !m_wrdy) | (rd_release && !m_rrdy) | ((|wr_en) && !m_wrdy);
      kcnt   <= kcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (run && rst_n) begin
      check("wr_ready", 128'(wr_ready), 128'(m_wrdy));
      check("rd_ready", 128'(rd_ready), 128'(m_rrdy));
      check("wr_sel",   128'(wr_sel),   128'(m_wsel));
      check("rd_sel",   128'(rd_sel),   128'(m_rsel));
      check("err",      128'(err),      128'(m_err));
      check("rd_valid", 128'(rd_valid), 128'(m_vld));
      check("rd_data",  128'(rd_data),  128'(m_dat));
    end
  end

  task automatic idle();
    wr_addr = '0; wr_data = '0; wr_en = '0; wr_done = 1'b0;
    rd_addr = '0; rd_en = '0; rd_release = 1'b0;
  endtask

  // One write per address; directed mode writes all lanes with {side, lane, addr}.
  task automatic fill(input bit directed, input logic [7:0] side, input bit rd_traffic);
    for (int a = 0; a < 256; a++) begin
      wr_addr = 8'(a);
      wr_en   = directed ? 4'hF : 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        wr_data[l] = directed ? {side, 8'(l), 16'(a)} : $urandom;
        rd_addr[l] = 8'($urandom);
      end
      rd_en = rd_traffic ? 4'($urandom) : 4'h0;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic pulse(input bit done, input bit rel);
    wr_done = done; rd_release = rel;
    @(negedge clk);
    idle();
  endtask

  task automatic rd1(input int lane, input logic [7:0] addr, output logic vld, output logic [31:0] dat);
    idle();
    rd_en[lane] = 1'b1; rd_addr[lane] = addr;
    @(negedge clk);
    idle();
    @(negedge clk);
    vld = rd_valid[lane];
    dat = rd_data[lane];
  endtask

  logic        v;
  logic [31:0] d, prior;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check("reset wr_ready", 128'(wr_ready), 128'(1));
    check("reset rd_ready", 128'(rd_ready), 128'(0));
    check("reset err",      128'(err),      128'(0));
    check("reset rd_valid", 128'(rd_valid), 128'(0));
    rst_n = 1'b1;
    run   = 1'b1;

    fill(1'b1, 8'd0, 1'b0);
    pulse(1'b1, 1'b0);
    check("fill0 wr_sel",   128'(wr_sel),   128'(1));
    check("fill0 rd_ready", 128'(rd_ready), 128'(1));
    check("fill0 rd_sel",   128'(rd_sel),   128'(0));
    rd1(2, 8'd17, v, d);
    check("lane2 addr17 valid", 128'(v), 128'(1));
    check("lane2 addr17 data",  128'(d), 128'(32'h0002_0011));

    fill(1'b1, 8'd1, 1'b1);
    pulse(1'b1, 1'b0);
    check("both full wr_ready", 128'(wr_ready), 128'(0));
    pulse(1'b0, 1'b1);
    check("release rd_sel",   128'(rd_sel),   128'(1));
    check("release wr_ready", 128'(wr_ready), 128'(1));
    check("release wr_sel",   128'(wr_sel),   128'(0));
    rd1(3, 8'd200, v, d);
    check("side1 lane3 addr200", 128'(d), 128'(32'h0103_00C8));

    fill(1'b0, 8'd0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    fill(1'b0, 8'd0, 1'b1);
    pulse(1'b1, 1'b1);
    check("simul wr_ready", 128'(wr_ready), 128'(1));
    check("simul rd_ready", 128'(rd_ready), 128'(1));
    check("simul rd_sel",   128'(rd_sel),   128'(1));
    check("simul wr_sel",   128'(wr_sel),   128'(0));
    check("simul err",      128'(err),      128'(0));

    prior = mm[1][9'd5];
    wr_addr = 8'd5; wr_en = 4'b0101;
    for (int l = 0; l < 4; l++) wr_data[l] = 32'hAAAA_0000 | 32'(l);
    @(negedge clk);
    idle();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    rd1(0, 8'd5, v, d);
    check("partial bank0", 128'(d), 128'(32'hAAAA_0000));
    rd1(2, 8'd5, v, d);
    check("partial bank2", 128'(d), 128'(32'hAAAA_0002));
    rd1(1, 8'd5, v, d);
    check("partial bank1 kept", 128'(d), 128'(prior));
    check("partial bank1 not written", 128'(d == 32'hAAAA_0001), 128'(0));

    pulse(1'b1, 1'b0);
    check("err before drop", 128'(err), 128'(0));
    wr_addr = 8'd5; wr_en = 4'h1; wr_data[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    idle();
    check("dropped write err", 128'(err), 128'(1));
    rd1(0, 8'd5, v, d);
    check("dropped write unchanged", 128'(d), 128'(32'hAAAA_0000));
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("bad release rd_sel", 128'(rd_sel), 128'(0));
    check("bad release wr_sel", 128'(wr_sel), 128'(0));
    check("err sticky",         128'(err),    128'(1));

    for (int c = 0; c < 1500; c++) begin
      wr_addr = 8'($urandom);
      wr_en   = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        wr_data[l] = $urandom;
        rd_addr[l] = 8'($urandom);
      end
      rd_en      = 4'($urandom);
      wr_done    = ($urandom_range(0, 39) == 0);
      rd_release = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    if (!rd_ready) pulse(1'b1, 1'b0);

    rd_en = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("mid-read rd_valid", 128'(rd_valid), 128'(4'hF));
    #1 rst_n = 1'b0;
    #1;
    check("async rd_valid", 128'(rd_valid), 128'(0));
    check("async rd_ready", 128'(rd_ready), 128'(0));
    check("async wr_ready", 128'(wr_ready), 128'(1));
    check("async wr_sel",   128'(wr_sel),   128'(0));
    check("async rd_sel",   128'(rd_sel),   128'(0));
    check("async err",      128'(err),      128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
